axi_mem_slave: RTL and testbench

- AXI-style memory responder; the slave end of the maxi_* interface driven by the core's AXI master bridge.
- Sits in soc between the bridge and an internal 64-bit word SRAM array. It replaces the direct core-to-mem path once the bridge is enabled.
- Independent write and read channels. Writes are single-beat with byte strobes. Reads are fixed-length incrementing bursts terminated by rlast.

---
 rtl/axi_mem_slave.sv | 174 +++++++++++++++++
 tb/tb_axi_mem_slave.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_slave.sv
// rtl/axi_mem_slave.sv - AXI-style memory responder: strobed single-beat writes, fixed-length incrementing read bursts
module axi_mem_slave #(
    parameter int          DEPTH     = 4096,
    parameter logic [63:0] ADDR_BASE = 64'h8000_0000,
    parameter int          RD_BEATS  = 4,
    parameter int          RD_LAT    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        saxi_waready,
    input  logic        saxi_wavalid,
    input  logic [63:0] saxi_waddr,
    output logic        saxi_wdready,
    input  logic        saxi_wdvalid,
    input  logic [63:0] saxi_wdata,
    input  logic [7:0]  saxi_wstrb,
    output logic        saxi_raready,
    input  logic        saxi_ravalid,
    input  logic [63:0] saxi_raddr,
    output logic        saxi_rdvalid,
    output logic [63:0] saxi_rdata,
    output logic        saxi_rlast,
    input  logic        saxi_rdready
);
    localparam int         AW        = $clog2(DEPTH);
    localparam logic [3:0] LAST_BEAT = 4'(RD_BEATS - 1);
    localparam logic [3:0] LAST_WAIT = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_WAIT, R_DATA} r_state_e;

    logic [63:0] mem [DEPTH];

    // Byte offset from the base, in words; the top bits fall away so out-of-range addresses alias.
    function automatic logic [AW-1:0] to_idx(input logic [63:0] addr);
        return AW'((addr - ADDR_BASE) >> 3);
    endfunction

    w_state_e      w_state_q, w_state_d;
    logic          waready_q, waready_d;
    logic          wdready_q, wdready_d;
    logic [AW-1:0] widx_q, widx_d;
    logic          wr_en;

    always_comb begin
        w_state_d = w_state_q;
        widx_d    = widx_q;
        case (w_state_q)
            W_IDLE: w_state_d = W_ADDR;
            W_ADDR: begin
                if (saxi_wavalid && waready_q) begin
                    widx_d    = to_idx(saxi_waddr);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (saxi_wdvalid && wdready_q) w_state_d = W_ADDR;
            end
            default: w_state_d = W_IDLE;
        endcase
        waready_d = (w_state_d == W_ADDR);
        wdready_d = (w_state_d == W_DATA);
        wr_en     = (w_state_q == W_DATA) && saxi_wdvalid && wdready_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            waready_q <= 1'b0;
            wdready_q <= 1'b0;
            widx_q    <= '0;
        end else begin
            w_state_q <= w_state_d;
            waready_q <= waready_d;
            wdready_q <= wdready_d;
            widx_q    <= widx_d;
        end
    end

    // Array is not reset; wr_en is built from reset flops so nothing commits while rst is high.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 8; i++) begin
                if (saxi_wstrb[i]) mem[widx_q][8*i +: 8] <= saxi_wdata[8*i +: 8];
            end
        end
    end

    r_state_e      r_state_q, r_state_d;
    logic          raready_q, raready_d;
    logic          rdvalid_q, rdvalid_d;
    logic          rlast_q, rlast_d;
    logic [63:0]   rdata_q, rdata_d;
    logic [AW-1:0] ridx_q, ridx_d;
    logic [3:0]    beat_q, beat_d;
    logic [3:0]    wait_q, wait_d;

    // rdata samples the array before the same-edge write lands, giving read-before-write on collision.
    always_comb begin
        r_state_d = r_state_q;
        ridx_d    = ridx_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: r_state_d = R_ADDR;
            R_ADDR: begin
                if (saxi_ravalid && raready_q) begin
                    ridx_d = to_idx(saxi_raddr);
                    beat_d = '0;
                    wait_d = '0;
                    if (RD_LAT == 0) begin
                        r_state_d = R_DATA;
                        rdata_d   = mem[ridx_d];
                    end else begin
                        r_state_d = R_WAIT;
                    end
                end
            end
            R_WAIT: begin
                if (wait_q == LAST_WAIT) begin
                    r_state_d = R_DATA;
                    rdata_d   = mem[ridx_q];
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            R_DATA: begin
                if (saxi_rdready && rdvalid_q) begin
                    if (rlast_q) begin
                        r_state_d = R_ADDR;
                    end else begin
                        beat_d  = beat_q + 4'd1;
                        ridx_d  = ridx_q + AW'(1);
                        rdata_d = mem[ridx_d];
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        raready_d = (r_state_d == R_ADDR);
        rdvalid_d = (r_state_d == R_DATA);
        rlast_d   = rdvalid_d && (beat_d == LAST_BEAT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            raready_q <= 1'b0;
            rdvalid_q <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            ridx_q    <= '0;
            beat_q    <= '0;
            wait_q    <= '0;
        end else begin
            r_state_q <= r_state_d;
            raready_q <= raready_d;
            rdvalid_q <= rdvalid_d;
            rlast_q   <= rlast_d;
            rdata_q   <= rdata_d;
            ridx_q    <= ridx_d;
            beat_q    <= beat_d;
            wait_q    <= wait_d;
        end
    end

    assign saxi_waready = waready_q;
    assign saxi_wdready = wdready_q;
    assign saxi_raready = raready_q;
    assign saxi_rdvalid = rdvalid_q;
    assign saxi_rlast   = rlast_q;
    assign saxi_rdata   = rdata_q;
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb/tb_axi_mem_slave.sv - self-checking bench for axi_mem_slave against a word-array reference model
module tb_axi_mem_slave;
    localparam int          DEPTH    = 4096;
    localparam logic [63:0] BASE     = 64'h8000_0000;
    localparam int          RD_BEATS = 4;
    localparam int          RD_LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        saxi_waready, saxi_wavalid = 1'b0;
    logic [63:0] saxi_waddr = '0;
    logic        saxi_wdready, saxi_wdvalid = 1'b0;
    logic [63:0] saxi_wdata = '0;
    logic [7:0]  saxi_wstrb = '0;
    logic        saxi_raready, saxi_ravalid = 1'b0;
    logic [63:0] saxi_raddr = '0;
    logic        saxi_rdvalid;
    logic [63:0] saxi_rdata;
    logic        saxi_rlast;
    logic        saxi_rdready = 1'b0;

    axi_mem_slave #(.DEPTH(DEPTH), .ADDR_BASE(BASE), .RD_BEATS(RD_BEATS), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .saxi_waready(saxi_waready), .saxi_wavalid(saxi_wavalid), .saxi_waddr(saxi_waddr),
        .saxi_wdready(saxi_wdready), .saxi_wdvalid(saxi_wdvalid), .saxi_wdata(saxi_wdata),
        .saxi_wstrb(saxi_wstrb),
        .saxi_raready(saxi_raready), .saxi_ravalid(saxi_ravalid), .saxi_raddr(saxi_raddr),
        .saxi_rdvalid(saxi_rdvalid), .saxi_rdata(saxi_rdata), .saxi_rlast(saxi_rlast),
        .saxi_rdready(saxi_rdready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [63:0] model [DEPTH];

    typedef struct {
        logic [63:0] addr;
        logic [63:0] pre;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs [6];

    function automatic int idx_of(input logic [63:0] a);
        logic [63:0] d;
        d = (a - BASE) / 64'd8;
        return int'(d % 64'(DEPTH));
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input int which);
        int n;
        n = 0;
        while (!(which == 0 ? saxi_waready : which == 1 ? saxi_wdready : saxi_raready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check($sformatf("ready%0d_timeout", which), 64'(n), 64'(0));
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        int i;
        saxi_waddr   = a;
        saxi_wavalid = 1'b1;
        wait_ready(0);
        @(negedge clk);
        saxi_wavalid = 1'b0;
        saxi_wdata   = d;
        saxi_wstrb   = s;
        saxi_wdvalid = 1'b1;
        wait_ready(1);
        @(negedge clk);
        saxi_wdvalid = 1'b0;
        i = idx_of(a);
        for (int b = 0; b < 8; b++) if (s[b]) model[i][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic do_read(input logic [63:0] a, input int stall_beat, input int stall_len,
                           output logic [63:0] first);
        int i, lat;
        logic [63:0] hold_d;
        logic hold_l;
        first = '0;
        i = idx_of(a);
        saxi_raddr   = a;
        saxi_ravalid = 1'b1;
        saxi_rdready = 1'b0;
        wait_ready(2);
        @(negedge clk);
        saxi_ravalid = 1'b0;
        lat = 0;
        while (!saxi_rdvalid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("rd_latency", 64'(lat), 64'(RD_LAT));
        saxi_rdready = 1'b1;
        for (int b = 0; b < RD_BEATS; b++) begin
            if (b == stall_beat) begin
                saxi_rdready = 1'b0;
                hold_d = saxi_rdata;
                hold_l = saxi_rlast;
                repeat (stall_len) begin
                    @(negedge clk);
                    check("bp_rdata", saxi_rdata, hold_d);
                    check("bp_rdvalid", 64'(saxi_rdvalid), 64'(1));
                    check("bp_rlast", 64'(saxi_rlast), 64'(hold_l));
                end
                saxi_rdready = 1'b1;
            end
            check($sformatf("rd_valid_b%0d", b), 64'(saxi_rdvalid), 64'(1));
            check($sformatf("rd_data_b%0d_idx%0d", b, i), saxi_rdata, model[i]);
            check($sformatf("rd_last_b%0d", b), 64'(saxi_rlast), 64'(b == RD_BEATS - 1));
            if (b == 0) first = saxi_rdata;
            @(negedge clk);
            i = (i + 1) % DEPTH;
        end
        saxi_rdready = 1'b0;
        check("rd_end_valid", 64'(saxi_rdvalid), 64'(0));
        check("rd_end_last", 64'(saxi_rlast), 64'(0));
        check("rd_end_raready", 64'(saxi_raready), 64'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, fails %0d", fails);
        $fatal(1);
    end

    initial begin
        logic [63:0] first, oldv, newv;
        int n;

        vecs[0] = '{64'h8000_0000, 64'h0, 64'h1122_3344_5566_7788, 8'hFF, 64'h1122_3344_5566_7788};
        vecs[1] = '{64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 8'h0F, 64'hFFFF_FFFF_0000_0000};
        vecs[2] = '{64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 64'h0123_4567_89AB_CDEF};
        vecs[3] = '{64'h8000_001D, 64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 8'h81, 64'h55AA_AAAA_AAAA_AA55};
        vecs[4] = '{64'h8000_8028, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 8'hF0, 64'hDEAD_BEEF_0000_0000};
        vecs[5] = '{64'h7FFF_FFF8, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 8'h3C, 64'h1111_2222_2222_1111};

        repeat (3) @(negedge clk);
        check("rst_waready", 64'(saxi_waready), 64'(0));
        check("rst_wdready", 64'(saxi_wdready), 64'(0));
        check("rst_raready", 64'(saxi_raready), 64'(0));
        check("rst_rdvalid", 64'(saxi_rdvalid), 64'(0));
        check("rst_rlast", 64'(saxi_rlast), 64'(0));
        check("rst_rdata", saxi_rdata, 64'(0));
        rst = 1'b0;
        #1;
        check("rel_raready_before_edge", 64'(saxi_raready), 64'(0));
        @(negedge clk);
        check("rel_waready", 64'(saxi_waready), 64'(1));
        check("rel_raready", 64'(saxi_raready), 64'(1));

        // Fill the whole array so every later read has a known expected value.
        for (int k = 0; k < DEPTH; k++) do_write(BASE + 64'(8 * k), {$urandom(), $urandom()}, 8'hFF);

        for (int k = 0; k < 6; k++) begin
            do_write(vecs[k].addr, vecs[k].pre, 8'hFF);
            do_write(vecs[k].addr, vecs[k].wdata, vecs[k].strb);
            do_read(vecs[k].addr, RD_BEATS, 0, first);
            check($sformatf("vec%0d_merge", k), first, vecs[k].exp);
        end

        do_read(BASE + 64'h8, 1, 3, first);
        do_read(BASE + 64'(8 * 4094), RD_BEATS, 0, first);

        // Collision: wd handshake lands on the edge that loads rdata from idx 0.
        oldv = model[0];
        newv = ~oldv ^ 64'h0F0F_0000_1234_5678;
        wait_ready(0);
        wait_ready(2);
        saxi_waddr = BASE; saxi_wavalid = 1'b1;
        saxi_raddr = BASE; saxi_ravalid = 1'b1;
        @(negedge clk);
        saxi_wavalid = 1'b0; saxi_ravalid = 1'b0;
        repeat (RD_LAT - 1) @(negedge clk);
        saxi_wdata = newv; saxi_wstrb = 8'hFF; saxi_wdvalid = 1'b1;
        @(negedge clk);
        saxi_wdvalid = 1'b0;
        check("coll_valid", 64'(saxi_rdvalid), 64'(1));
        check("coll_old_data", saxi_rdata, oldv);
        saxi_rdready = 1'b1;
        repeat (RD_BEATS) @(negedge clk);
        saxi_rdready = 1'b0;
        model[0] = newv;
        do_read(BASE, RD_BEATS, 0, first);
        check("coll_new_data", first, newv);

        // Reset during the second beat of a burst.
        saxi_raddr = BASE + 64'(8 * 10); saxi_ravalid = 1'b1;
        wait_ready(2);
        @(negedge clk);
        saxi_ravalid = 1'b0;
        saxi_rdready = 1'b1;
        n = 0;
        while (!saxi_rdvalid && n < 40) begin @(negedge clk); n++; end
        @(negedge clk);
        check("mid_beat2_valid", 64'(saxi_rdvalid), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rdvalid", 64'(saxi_rdvalid), 64'(0));
        check("mid_rst_rdata", saxi_rdata, 64'(0));
        check("mid_rst_rlast", 64'(saxi_rlast), 64'(0));
        check("mid_rst_raready", 64'(saxi_raready), 64'(0));
        check("mid_rst_waready", 64'(saxi_waready), 64'(0));
        saxi_rdready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rel_raready_pre", 64'(saxi_raready), 64'(0));
        @(negedge clk);
        check("mid_rel_raready", 64'(saxi_raready), 64'(1));
        do_read(BASE + 64'(8 * 10), RD_BEATS, 0, first);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 1)
                do_write({$urandom(), $urandom()}, {$urandom(), $urandom()}, 8'($urandom_range(0, 255)));
            else
                do_read({$urandom(), $urandom()}, $urandom_range(0, RD_BEATS), $urandom_range(1, 3), first);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
